// File: rtl/m_store_narrow_if.sv
`timescale 1ns/1ps
// Data-bus bridge write channel between the M-stage store unit and the system bridge.
// Latency: none, wires only; the store unit registers every field it drives.
// Backpressure: bus_req is held with stable fields until the bridge answers with bus_ack.
interface m_store_narrow_if;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_byteen;
    logic [31:0] bus_wdata;
    logic        bus_ack;

    modport master (
        output bus_req,
        output bus_addr,
        output bus_byteen,
        output bus_wdata,
        input  bus_ack
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        input  bus_byteen,
        input  bus_wdata,
        output bus_ack
    );
endinterface

// File: rtl/m_store_narrow.sv
`timescale 1ns/1ps
// M-stage store unit: narrows sb/sh/sw data onto byte lanes and runs one req/ack bus write.
// Latency: req the cycle after capture; done (or bus_err on TIMEOUT) one cycle after the ack edge.
// Backpressure: stall holds F/D/E/M from capture until the retire cycle. Option: STORE_ALIGN_CHK_EN.
module m_store_narrow #(
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid,
    input  logic [1:0]             StoreOp,
    input  logic [31:0]            addr,
    input  logic [31:0]            wdata,
    m_store_narrow_if.master       bus,
    output logic                   stall,
    output logic                   done,
    output logic                   bus_err,
    output logic                   exc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic        live;
    logic        start;
    logic        ack_hit;
    logic        to_hit;
    logic [7:0]  cnt;
    logic [3:0]  lane_be;
    logic [31:0] lane_dat;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] dat_q;
    logic        done_q;
    logic        err_q;

    // Reset also masks the instruction so stall/exc read 0 while reset is held.
    assign live = valid & reset;

`ifdef STORE_ALIGN_CHK_EN
    logic misalign;

    // Halfword on an odd byte or word off a word boundary raises AdES instead of writing.
    always_comb begin
        misalign = 1'b0;
        if (StoreOp == 2'b10)
            misalign = addr[0];
        else if (StoreOp == 2'b11)
            misalign = (addr[1:0] != 2'b00);
    end

    assign exc = live & (state == IDLE) & misalign;
`else
    assign exc = 1'b0;
`endif

    // Lane map: replicate the narrow value across the word, enable only the addressed lanes.
    always_comb begin
        lane_be  = 4'b0000;
        lane_dat = 32'h0;
        case (StoreOp)
            2'b01: begin
                lane_be  = 4'b0001 << addr[1:0];
                lane_dat = {4{wdata[7:0]}};
            end
            2'b10: begin
                lane_be  = addr[1] ? 4'b1100 : 4'b0011;
                lane_dat = {2{wdata[15:0]}};
            end
            2'b11: begin
                lane_be  = 4'b1111;
                lane_dat = wdata;
            end
            default: begin
                lane_be  = 4'b0000;
                lane_dat = 32'h0;
            end
        endcase
    end

    // Next state: capture in IDLE, wait for ack (which beats a same-cycle timeout), retire once.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ack_hit   = 1'b0;
        to_hit    = 1'b0;
        case (state)
            IDLE: begin
                if (live && (StoreOp != 2'b00) && !exc) begin
                    start     = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.bus_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == TO_LAST) begin
                    to_hit    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register; async reset abandons any outstanding write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Bus fields, wait counter and retire pulses; fields change only on capture and clear on retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= 8'd0;
            addr_q <= 32'h0;
            be_q   <= 4'b0000;
            dat_q  <= 32'h0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= ack_hit;
            err_q  <= to_hit;
            if (start) begin
                cnt    <= 8'd0;
                addr_q <= {addr[31:2], 2'b00};
                be_q   <= lane_be;
                dat_q  <= lane_dat;
            end else if (ack_hit || to_hit) begin
                cnt    <= 8'd0;
                addr_q <= 32'h0;
                be_q   <= 4'b0000;
                dat_q  <= 32'h0;
            end else if (state == WAIT) begin
                cnt    <= cnt + 8'd1;
            end
        end
    end

    // Request is decoded straight from state so an async reset drops it immediately.
    assign bus.bus_req    = (state == WAIT);
    assign bus.bus_addr   = addr_q;
    assign bus.bus_byteen = be_q;
    assign bus.bus_wdata  = dat_q;
    assign stall          = start | (state == WAIT);
    assign done           = done_q;
    assign bus_err        = err_q;

endmodule

// File: tb/tb_m_store_narrow.sv
`timescale 1ns/1ps
// Directed bench for m_store_narrow with a scoreboard of expected bus writes.
// Latency: DUT built with TIMEOUT=4 so the abort path is reached quickly.
// Backpressure: bench holds the instruction while stall is high and acks on a chosen WAIT cycle.
module tb_m_store_narrow;
    localparam int TO = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [1:0]  StoreOp;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        bus_err;
    logic        exc;

    txn_t sb_q[$];
    int   total  = 0;
    int   passed = 0;

    m_store_narrow_if bif();

    m_store_narrow #(.TIMEOUT(TO)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid   (valid),
        .StoreOp (StoreOp),
        .addr    (addr),
        .wdata   (wdata),
        .bus     (bif),
        .stall   (stall),
        .done    (done),
        .bus_err (bus_err),
        .exc     (exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the bus fields of the first request cycle against the oldest expected write.
    task automatic pop_cmp(input string tag);
        txn_t e;
        check({tag, "_sb_depth"}, 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({tag, "_bus_addr"},   bif.bus_addr,          e.a);
            check({tag, "_bus_byteen"}, 32'(bif.bus_byteen),   32'(e.be));
            check({tag, "_bus_wdata"},  bif.bus_wdata,         e.d);
        end
    endtask

    // Present one store, ack on WAIT cycle ack_at (0 = never), and check the whole transaction.
    task automatic do_store(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] d, input int ack_at, input txn_t exp,
                            input int exp_stall, input int exp_req, input bit exp_done);
        int n_stall = 0;
        int n_req   = 0;
        int n_done  = 0;
        int n_err   = 0;
        int widx    = 0;
        bit fin     = 1'b0;
        step();
        valid       = 1'b1;
        StoreOp     = op;
        addr        = a;
        wdata       = d;
        bif.bus_ack = 1'b0;
        sb_q.push_back(exp);
        #4;
        check({tag, "_start_stall"}, 32'(stall), 32'd1);
        check({tag, "_start_req"},   32'(bif.bus_req), 32'd0);
        check({tag, "_start_done"},  32'(done), 32'd0);
        n_stall += int'(stall);
        for (int c = 0; c < 300 && !fin; c++) begin
            step();
            bif.bus_ack = 1'b0;
            if (bif.bus_req) begin
                widx++;
                if (widx == 1)
                    pop_cmp(tag);
                bif.bus_ack = (widx == ack_at);
            end
            #4;
            n_stall += int'(stall);
            n_req   += int'(bif.bus_req);
            n_done  += int'(done);
            n_err   += int'(bus_err);
            if (done || bus_err) begin
                fin = 1'b1;
                bif.bus_ack = 1'b0;
                check({tag, "_retire_req"},    32'(bif.bus_req), 32'd0);
                check({tag, "_retire_stall"},  32'(stall), 32'd0);
                check({tag, "_retire_addr"},   bif.bus_addr, 32'h0);
                check({tag, "_retire_byteen"}, 32'(bif.bus_byteen), 32'd0);
                check({tag, "_retire_wdata"},  bif.bus_wdata, 32'h0);
            end
        end
        check({tag, "_retired"},    32'(fin), 32'd1);
        check({tag, "_stall_cyc"},  32'(n_stall), 32'(exp_stall));
        check({tag, "_req_cyc"},    32'(n_req), 32'(exp_req));
        check({tag, "_done_cnt"},   32'(n_done), exp_done ? 32'd1 : 32'd0);
        check({tag, "_err_cnt"},    32'(n_err), exp_done ? 32'd0 : 32'd1);
    endtask

    // One cycle with no live instruction after a retire: pulses must have ended.
    task automatic idle_cycle(input string tag);
        step();
        valid   = 1'b0;
        StoreOp = 2'b00;
        #4;
        check({tag, "_idle_done"},  32'(done), 32'd0);
        check({tag, "_idle_err"},   32'(bus_err), 32'd0);
        check({tag, "_idle_stall"}, 32'(stall), 32'd0);
        check({tag, "_idle_req"},   32'(bif.bus_req), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        valid       = 1'b0;
        StoreOp     = 2'b00;
        addr        = 32'h0;
        wdata       = 32'h0;
        bif.bus_ack = 1'b0;

        #12;
        check("rst_req",    32'(bif.bus_req), 32'd0);
        check("rst_addr",   bif.bus_addr, 32'h0);
        check("rst_byteen", 32'(bif.bus_byteen), 32'd0);
        check("rst_stall",  32'(stall), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_err",    32'(bus_err), 32'd0);
        check("rst_exc",    32'(exc), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted in the middle of WAIT abandons the write at once.
        step();
        valid   = 1'b1;
        StoreOp = 2'b11;
        addr    = 32'h0000_7000;
        wdata   = 32'h1111_2222;
        sb_q.push_back(txn_t'{a: 32'h0000_7000, be: 4'b1111, d: 32'h1111_2222});
        step();
        check("midrst_req_before", 32'(bif.bus_req), 32'd1);
        pop_cmp("midrst");
        #1;
        reset   = 1'b0;
        valid   = 1'b0;
        StoreOp = 2'b00;
        #1;
        check("midrst_req",    32'(bif.bus_req), 32'd0);
        check("midrst_addr",   bif.bus_addr, 32'h0);
        check("midrst_byteen", 32'(bif.bus_byteen), 32'd0);
        check("midrst_wdata",  bif.bus_wdata, 32'h0);
        check("midrst_stall",  32'(stall), 32'd0);
        check("midrst_done",   32'(done), 32'd0);
        check("midrst_err",    32'(bus_err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();
        #4;
        check("postrst_req",   32'(bif.bus_req), 32'd0);
        check("postrst_stall", 32'(stall), 32'd0);

        // No-action cases: op none, invalid slot, and a stray ack outside WAIT.
        step();
        valid       = 1'b1;
        StoreOp     = 2'b00;
        addr        = 32'h0000_1000;
        #4;
        check("noop_stall", 32'(stall), 32'd0);
        step();
        valid       = 1'b0;
        StoreOp     = 2'b10;
        bif.bus_ack = 1'b1;
        #4;
        check("invalid_stall", 32'(stall), 32'd0);
        step();
        #4;
        check("stray_ack_req",  32'(bif.bus_req), 32'd0);
        check("stray_ack_done", 32'(done), 32'd0);
        bif.bus_ack = 1'b0;
        StoreOp     = 2'b00;

        // sb at byte 3, ack on the second WAIT cycle.
        do_store("sb_b3", 2'b01, 32'h0000_1003, 32'h1234_56AB, 2,
                 txn_t'{a: 32'h0000_1000, be: 4'b1000, d: 32'hABAB_ABAB}, 3, 2, 1'b1);
        idle_cycle("sb_b3");

        // sh upper half, minimum latency ack.
        do_store("sh_hi", 2'b10, 32'h0000_2002, 32'hDEAD_BEEF, 1,
                 txn_t'{a: 32'h0000_2000, be: 4'b1100, d: 32'hBEEF_BEEF}, 2, 1, 1'b1);
        idle_cycle("sh_hi");

        // sw with no ack: TIMEOUT request cycles then a bus_err pulse.
        do_store("sw_to", 2'b11, 32'h0000_3000, 32'hCAFE_BABE, 0,
                 txn_t'{a: 32'h0000_3000, be: 4'b1111, d: 32'hCAFE_BABE}, TO + 1, TO, 1'b0);
        idle_cycle("sw_to");

        // Ack on the very cycle the timeout would fire: ack wins.
        do_store("sw_race", 2'b11, 32'h0000_3100, 32'h0BAD_F00D, TO,
                 txn_t'{a: 32'h0000_3100, be: 4'b1111, d: 32'h0BAD_F00D}, TO + 1, TO, 1'b1);
        idle_cycle("sw_race");

`ifdef STORE_ALIGN_CHK_EN
        // Misaligned sw raises AdES combinationally and never reaches the bus.
        step();
        valid   = 1'b1;
        StoreOp = 2'b11;
        addr    = 32'h0000_3002;
        wdata   = 32'hA5A5_5A5A;
        #4;
        check("mis_exc",   32'(exc), 32'd1);
        check("mis_stall", 32'(stall), 32'd0);
        check("mis_req",   32'(bif.bus_req), 32'd0);
        step();
        valid   = 1'b0;
        StoreOp = 2'b00;
        #4;
        check("mis_req_after", 32'(bif.bus_req), 32'd0);
        check("mis_exc_after", 32'(exc), 32'd0);
`else
        // Misaligned sw without the check writes all lanes of the aligned word.
        do_store("sw_mis", 2'b11, 32'h0000_3002, 32'hA5A5_5A5A, 1,
                 txn_t'{a: 32'h0000_3000, be: 4'b1111, d: 32'hA5A5_5A5A}, 2, 1, 1'b1);
        check("mis_exc", 32'(exc), 32'd0);
        idle_cycle("sw_mis");
`endif

        // Back-to-back stores, each presented in the IDLE cycle right after the previous retire.
        do_store("b2b_sb", 2'b01, 32'h0000_4001, 32'h0000_00C3, 1,
                 txn_t'{a: 32'h0000_4000, be: 4'b0010, d: 32'hC3C3_C3C3}, 2, 1, 1'b1);
        do_store("b2b_sw", 2'b11, 32'h0000_5004, 32'hCAFE_F00D, 1,
                 txn_t'{a: 32'h0000_5004, be: 4'b1111, d: 32'hCAFE_F00D}, 2, 1, 1'b1);
        do_store("b2b_sh", 2'b10, 32'h0000_6000, 32'h1234_F00D, 1,
                 txn_t'{a: 32'h0000_6000, be: 4'b0011, d: 32'hF00D_F00D}, 2, 1, 1'b1);
        idle_cycle("b2b");

        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
